// File: rtl/fp_pkg.sv
// Shared binary32 field widths, integer limits and FSM/class types for the
// float-to-int conversion blocks.
package fp_pkg;

  localparam int DATA_W   = 32;
  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int EXP_BIAS = 127;

  // 158 = first exponent whose value cannot fit below 2^31
  localparam logic [EXP_W-1:0] EXP_OVF      = EXP_W'(EXP_BIAS + DATA_W - 1);
  localparam logic [EXP_W-1:0] EXP_ONE_HALF = EXP_W'(EXP_BIAS - 1);
  localparam logic [EXP_W-1:0] EXP_SPECIAL  = '1;

  localparam logic [DATA_W-1:0] INT32_MAX    = 32'h7FFF_FFFF;
  localparam logic [DATA_W-1:0] INT32_MIN    = 32'h8000_0000;
  localparam logic [DATA_W-1:0] INT32_MIN_FP = 32'hCF00_0000;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    ROUND,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    CLS_NORM,
    CLS_HALF,
    CLS_TINY,
    CLS_ZERO,
    CLS_DENORM,
    CLS_NAN,
    CLS_INF,
    CLS_BIG
  } fp_class_t;

  // 158 - e taken modulo 32; only meaningful for exponents 127..158
  function automatic logic [4:0] shift_amount(input logic [4:0] exp_lo);
    logic [4:0] limit_lo;
    limit_lo = EXP_OVF[4:0];
    return limit_lo - exp_lo;
  endfunction

endpackage

// File: rtl/fp32_classify.sv
// Combinational unpack of a binary32 operand: sign, fraction, input class and
// the right-shift amount that aligns the significand to an integer.
module fp32_classify
  import fp_pkg::*;
(
  input  logic [DATA_W-1:0] operand,
  output logic              sign,
  output logic [FRAC_W-1:0] frac,
  output logic [4:0]        shamt,
  output logic [2:0]        cls
);

  logic [EXP_W-1:0] exp_f;
  fp_class_t        cls_e;

  assign sign  = operand[31];
  assign exp_f = operand[30:23];
  assign frac  = operand[22:0];
  assign shamt = shift_amount(exp_f[4:0]);
  assign cls   = cls_e;

  // -2^31 is the one exponent-158 value that still fits, so it stays NORM
  always_comb begin
    cls_e = CLS_NORM;
    if (exp_f == EXP_SPECIAL) begin
      cls_e = (frac != '0) ? CLS_NAN : CLS_INF;
    end else if (exp_f >= EXP_OVF && operand != INT32_MIN_FP) begin
      cls_e = CLS_BIG;
    end else if (exp_f == '0) begin
      cls_e = (frac != '0) ? CLS_DENORM : CLS_ZERO;
    end else if (exp_f < EXP_ONE_HALF) begin
      cls_e = CLS_TINY;
    end else if (exp_f == EXP_ONE_HALF) begin
      cls_e = CLS_HALF;
    end
  end

endmodule

// File: rtl/fp32_to_int32.sv
// Multi-cycle binary32 to int32 converter: five serial shift steps, one round
// step, then a held result. Define FP32_TO_INT32_RNE_EN for round-to-nearest-even;
// otherwise the result truncates toward zero.
module fp32_to_int32
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_invalid,
  output logic        out_overflow,
  output logic        out_inexact
);

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        step;
  logic              accept;

  logic              c_sign;
  logic [FRAC_W-1:0] c_frac;
  logic [4:0]        c_shamt;
  logic [2:0]        c_cls;
  fp_class_t         c_cls_e;

  logic              sign_r;
  fp_class_t         cls_r;
  logic [4:0]        shamt_r;
  logic [31:0]       mag;
  logic              guard;
  logic              sticky;

  logic [31:0]       mag_nxt;
  logic              guard_nxt;
  logic              sticky_nxt;

  logic              rnd_inc;
  logic [32:0]       sat;
  logic [31:0]       res_data;
  logic              res_inv;
  logic              res_ovf;
  logic              res_inx;

  function automatic logic [32:0] round_mag(input logic [31:0] m, input logic inc);
    return {1'b0, m} + {32'd0, inc};
  endfunction

`ifdef FP32_TO_INT32_RNE_EN
  function automatic logic rne_inc(input logic g, input logic s, input logic lsb);
    return g & (s | lsb);
  endfunction
`endif

  // Returns {overflow, two's-complement result}
  function automatic logic [32:0] saturate(input logic neg, input logic [32:0] mag33);
    logic signed [31:0] val;
    logic               ovf;
    val = signed'(mag33[31:0]);
    ovf = 1'b0;
    if (!neg) begin
      if (mag33 > {1'b0, INT32_MAX}) begin
        ovf = 1'b1;
        val = signed'(INT32_MAX);
      end
    end else if (mag33 > {1'b0, INT32_MIN}) begin
      ovf = 1'b1;
      val = signed'(INT32_MIN);
    end else begin
      val = -val;
    end
    return {ovf, val};
  endfunction

  fp32_classify u_classify (
    .operand (in_data),
    .sign    (c_sign),
    .frac    (c_frac),
    .shamt   (c_shamt),
    .cls     (c_cls)
  );

  assign c_cls_e = fp_class_t'(c_cls);
  assign accept  = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      step  <= '0;
    end else begin
      state <= state_nxt;
      step  <= (state == SHIFT) ? step + 3'd1 : 3'd0;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid && rst_n) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (step == 3'd4) state_nxt = ROUND;
      end
      ROUND: begin
        state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One shift step per SHIFT cycle, largest first, so each step's shifted-out
  // bits outrank everything already folded into guard/sticky.
  always_comb begin
    mag_nxt    = mag;
    guard_nxt  = guard;
    sticky_nxt = sticky;
    case (step)
      3'd0: if (shamt_r[4]) begin
        mag_nxt    = mag >> 16;
        guard_nxt  = mag[15];
        sticky_nxt = sticky | guard | (|mag[14:0]);
      end
      3'd1: if (shamt_r[3]) begin
        mag_nxt    = mag >> 8;
        guard_nxt  = mag[7];
        sticky_nxt = sticky | guard | (|mag[6:0]);
      end
      3'd2: if (shamt_r[2]) begin
        mag_nxt    = mag >> 4;
        guard_nxt  = mag[3];
        sticky_nxt = sticky | guard | (|mag[2:0]);
      end
      3'd3: if (shamt_r[1]) begin
        mag_nxt    = mag >> 2;
        guard_nxt  = mag[1];
        sticky_nxt = sticky | guard | mag[0];
      end
      default: if (shamt_r[0]) begin
        mag_nxt    = mag >> 1;
        guard_nxt  = mag[0];
        sticky_nxt = sticky | guard;
      end
    endcase
  end

  // Values below 1.0 never shift: their guard/sticky are loaded directly
  always_ff @(posedge clk) begin
    if (accept) begin
      sign_r  <= c_sign;
      cls_r   <= c_cls_e;
      shamt_r <= (c_cls_e == CLS_NORM) ? c_shamt : 5'd0;
      mag     <= (c_cls_e == CLS_NORM) ? {1'b1, c_frac, 8'b0} : 32'd0;
      guard   <= (c_cls_e == CLS_HALF);
      sticky  <= (c_cls_e == CLS_HALF) ? (|c_frac)
                                       : (c_cls_e == CLS_TINY || c_cls_e == CLS_DENORM);
    end else if (state == SHIFT) begin
      mag    <= mag_nxt;
      guard  <= guard_nxt;
      sticky <= sticky_nxt;
    end
  end

  always_comb begin
`ifdef FP32_TO_INT32_RNE_EN
    rnd_inc = rne_inc(guard, sticky, mag[0]);
`else
    rnd_inc = 1'b0;
`endif
    sat      = saturate(sign_r, round_mag(mag, rnd_inc));
    res_data = '0;
    res_inv  = 1'b0;
    res_ovf  = 1'b0;
    res_inx  = 1'b0;
    case (cls_r)
      CLS_NAN: begin
        res_data = INT32_MAX;
        res_inv  = 1'b1;
      end
      CLS_INF, CLS_BIG: begin
        res_data = sign_r ? INT32_MIN : INT32_MAX;
        res_ovf  = 1'b1;
      end
      default: begin
        res_data = sat[31:0];
        res_ovf  = sat[32];
        res_inx  = (guard | sticky) & ~sat[32];
      end
    endcase
  end

  // Result registers load only in ROUND, which holds them through a DONE stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data     <= '0;
      out_invalid  <= 1'b0;
      out_overflow <= 1'b0;
      out_inexact  <= 1'b0;
    end else if (state == ROUND) begin
      out_data     <= res_data;
      out_invalid  <= res_inv;
      out_overflow <= res_ovf;
      out_inexact  <= res_inx;
    end
  end

endmodule

// File: tb/tb_fp32_to_int32.sv
// Scoreboard bench for fp32_to_int32: randomized and directed operands against a
// remainder-based numeric model; follows FP32_TO_INT32_RNE_EN like the design.
module tb_fp32_to_int32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_invalid;
  logic        out_overflow;
  logic        out_inexact;

  typedef struct packed {
    logic [31:0] data;
    logic        inv;
    logic        ovf;
    logic        inx;
  } res_t;

  localparam longint LMAX = 64'sd2147483647;
  localparam longint LMIN = -64'sd2147483648;

  res_t exp_q[$];
  int   acc_q[$];
  int   tests = 0;
  int   fails = 0;
  int   edges = 0;
  logic rand_ready = 1'b1;

  fp32_to_int32 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_invalid  (out_invalid),
    .out_overflow (out_overflow),
    .out_inexact  (out_inexact)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  // Value = m * 2^(e-150); integer part and the discarded remainder decide the result
  function automatic res_t model(input logic [31:0] f);
    res_t            res;
    logic            s;
    int              e;
    int              sh;
    longint unsigned m, ip, rem, half;
    longint          r;
    logic            inexact, up;
    s = f[31];
    e = int'(f[30:23]);
    m = {40'd0, 1'b1, f[22:0]};
    res = '0;
    ip = 0; inexact = 1'b0; up = 1'b0;
    if (e == 255 && f[22:0] != 23'd0) begin
      res.data = 32'h7FFF_FFFF;
      res.inv  = 1'b1;
      return res;
    end
    if (e >= 159) begin
      res.data = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
      res.ovf  = 1'b1;
      return res;
    end
    if (e == 0) begin
      inexact = (f[22:0] != 23'd0);
    end else if (e >= 150) begin
      ip = m << (e - 150);
    end else if (150 - e >= 40) begin
      inexact = 1'b1;
    end else begin
      sh   = 150 - e;
      ip   = m >> sh;
      rem  = m & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      inexact = (rem != 0);
`ifdef FP32_TO_INT32_RNE_EN
      up = (rem > half) || (rem == half && ip[0]);
`endif
    end
    ip = ip + {63'd0, up};
    r  = s ? -longint'(ip) : longint'(ip);
    if (r > LMAX || r < LMIN) begin
      res.data = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
      res.ovf  = 1'b1;
    end else begin
      res.data = r[31:0];
      res.inx  = inexact;
    end
    return res;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] op;
    logic [7:0]  e;
    logic [22:0] fr;
    int          k;
    op = $urandom;
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5: begin
        e  = 8'($urandom_range(118, 160));
        op = {op[31], e, op[22:0]};
      end
      6: begin
        k  = int'($urandom_range(0, 13));
        fr = 23'($urandom) & ~((23'd1 << (23 - k)) - 23'd1);
        fr = fr | (23'd1 << (22 - k));
        e  = 8'(127 + k);
        op = {op[31], e, fr};
      end
      7: begin
        case ($urandom_range(0, 3))
          0: op = {op[31], 8'hFF, op[22:0] | 23'd1};
          1: op = {op[31], 8'hFF, 23'd0};
          2: op = {op[31], 31'd0};
          default: op = {op[31], 8'h00, op[22:0] | 23'd1};
        endcase
      end
      8: begin
        e  = 8'($urandom_range(0, 125));
        op = {op[31], e, op[22:0]};
      end
      default: ;
    endcase
    return op;
  endfunction

  // Must be entered just after a rising edge; keeps junk on the inputs while busy
  task automatic send(input logic [31:0] op);
    int waited;
    waited = 0;
    while (!in_ready && waited < 200) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
      in_valid = 1'b0;
      return;
    end
    in_valid = 1'b1;
    in_data  = op;
    exp_q.push_back(model(op));
    acc_q.push_back(edges + 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 500) begin
      @(posedge clk); #1;
      waited++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  initial forever begin
    @(posedge clk); #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: latency on the first cycle of out_valid, payload on each handshake
  initial begin
    logic prev_valid;
    int   lat;
    res_t want;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
      end else begin
        if (out_valid && !prev_valid) begin
          if (acc_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_valid: out_valid 1 with no operand outstanding");
          end else begin
            lat = edges - acc_q[0] + 1;
            check("latency_edges", 36'(lat), 36'd7);
          end
        end
        if (out_valid && out_ready && exp_q.size() != 0) begin
          want = exp_q.pop_front();
          if (acc_q.size() != 0) void'(acc_q.pop_front());
          check("result", {out_data, 1'b0, out_invalid, out_overflow, out_inexact},
                {want.data, 1'b0, want.inv, want.ovf, want.inx});
        end
        prev_valid = out_valid;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] directed [17];
    int          w;
    directed = '{32'h3FC00000, 32'h40200000, 32'hC2F60000, 32'hCF000000, 32'h4F000000,
                 32'hFF800000, 32'h7FC00000, 32'h00000000, 32'h80000000, 32'h00000001,
                 32'h3F000000, 32'hBF400000, 32'h4EFFFFFF, 32'hCEFFFFFF, 32'h3F800000,
                 32'h7F800000, 32'hCF000001};

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {35'd0, out_valid}, 36'd0);
    check("rst_in_ready", {35'd0, in_ready}, 36'd0);
    check("rst_out_data", {4'd0, out_data}, 36'd0);
    check("rst_flags", {33'd0, out_invalid, out_overflow, out_inexact}, 36'd0);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_rst", {35'd0, in_ready}, 36'd1);
    @(posedge clk); #1;

    foreach (directed[i]) send(directed[i]);
    drain();
    for (int n = 0; n < 150; n++) send(rand_op());
    drain();

    // Stall in DONE: outputs must hold the expected result and in_ready stay low
    rand_ready = 1'b0;
    out_ready  = 1'b0;
    send(32'hC2F60000);
    w = 0;
    while (!out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("stall_valid_seen", {35'd0, out_valid}, 36'd1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        check("stall_hold", {out_data, 1'b0, out_invalid, out_overflow, out_inexact},
              {exp_q[0].data, 1'b0, exp_q[0].inv, exp_q[0].ovf, exp_q[0].inx});
      end
      check("stall_in_ready", {34'd0, in_ready, out_valid}, 36'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_handshake", {35'd0, in_ready}, 36'd1);
    send(32'h40200000);
    drain();
    rand_ready = 1'b1;

    // Asynchronous reset while a conversion is in SHIFT
    send(32'h4B123456);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {34'd0, out_valid, in_ready}, 36'd0);
    check("async_rst_data", {out_data, 1'b0, out_invalid, out_overflow, out_inexact}, 36'd0);
    exp_q.delete();
    acc_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("in_ready_after_abort", {35'd0, in_ready}, 36'd1);
    send(32'h3F800000);
    drain();
    for (int n = 0; n < 20; n++) send(rand_op());
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
